lcd_text_controller: RTL and testbench
======================================

Name: lcd_text_controller

Overview:
Sequences writes into the 32-cell LCD character RAM from decoded keyboard events. It sits between the keycode recognizer / keycode-to-ASCII path and the LCD RAM write port. It replaces the free-running write-address counter with a cursor-based editor:
- printable characters are written at the cursor
- backspace, enter and escape are handled as editing commands
- the display is cleared automatically after reset and on request

Parameters:
DEPTH, 32, number of character cells (two lines); must be 2*LINE_LEN
LINE_LEN, 16, cells per LCD line
ADDR_W, 5, width of RAM address / cursor; 2**ADDR_W == DEPTH
FILL_CHAR, 8'h20, character written by clear and backspace

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse: new keycode decoded
key_make  in  1  1 = make code, 0 = break code; qualified by key_valid
key_ascii  in  8  ASCII of the key; qualified by key_valid
clear_req  in  1  one-cycle pulse: request full-screen clear
ram_we  out  1  LCD RAM write enable
ram_waddr  out  ADDR_W  LCD RAM write address
ram_wdata  out  8  LCD RAM write data
cursor  out  ADDR_W  current cursor cell
busy  out  1  high while clearing
drop  out  1  one-cycle pulse: accepted key was discarded

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset_n=0) sets:
  - state=CLEAR, clr_cnt=0, cursor=0
  - ram_we=0, ram_waddr=0, ram_wdata=FILL_CHAR
  - busy=1, drop=0
- States: CLEAR and IDLE.
- CLEAR state:
  - Each edge registers ram_we=1, ram_waddr=clr_cnt, ram_wdata=FILL_CHAR, then clr_cnt+1.
  - The edge that registers address DEPTH-1 is the last write.
  - On the next edge: ram_we=0, busy=0, cursor=0, state=IDLE.
  - Result: exactly DEPTH consecutive write cycles, addresses 0..DEPTH-1 in order, with no gaps.
- Accepted event: key_valid=1 and key_make=1. Break codes (key_make=0) are ignored silently, with no drop pulse.
- Event arriving in CLEAR: discarded; drop=1 on the next cycle. clear_req in CLEAR is ignored (the sequence is not restarted).
- clear_req in IDLE: on the next edge, state=CLEAR and clr_cnt=0. If an accepted event arrives in the same cycle, clear wins, the key is discarded, and drop=1.
- In IDLE, an accepted event is classified by key_ascii. Write latency is 1 cycle: ram_we is high on the cycle after key_valid, for exactly 1 cycle.
  - 8'h20..8'h7E (printable): write key_ascii at cursor; cursor <= cursor+1, wrapping DEPTH-1 -> 0.
  - 8'h08 (backspace):
    - cursor==0: no write, no change.
    - otherwise: cursor <= cursor-1, and write FILL_CHAR at cursor-1.
  - 8'h0D (enter): cursor <= (cursor < LINE_LEN) ? LINE_LEN : 0. No write.
  - 8'h1B (escape): same as clear_req.
  - Any other value: ignored, no drop.
- ram_we=0 on every cycle not listed above. ram_waddr and ram_wdata hold their last values when ram_we=0.
- cursor updates on the same edge that registers the corresponding write.
- Back-to-back accepted events on consecutive cycles are each processed; there is no internal stall in IDLE.
- Reset asserted mid-clear or mid-write: immediate return to reset values, and the clear sequence restarts from address 0 after release.

Test Plan:
1. Release reset -> ram_we high for 32 consecutive cycles, addresses 0..31, data 8'h20. Then busy=0, cursor=0.
2. After clear, send make events 'A'(8'h41) and 'B'(8'h42) -> writes (0,8'h41) and (1,8'h42), each one cycle after key_valid; cursor=2. A break event for 'A' -> no write.
3. cursor=0, send backspace 8'h08 -> no write, cursor stays 0. Send 'C', then backspace -> write (0,8'h43), then write (0,8'h20); cursor=0.
4. cursor=5, send 8'h0D -> cursor=16, no write. Send 8'h0D again -> cursor=0. Fill 32 printable chars -> last write at address 31, cursor wraps to 0.
5. Send 8'h1B -> busy=1, 32 fill writes, cursor=0. Send a key at clear cycle 10 -> drop pulse one cycle later, and the write sequence is uninterrupted. A clear_req pulse during clear -> ignored, still 32 writes total.
6. clear_req and key 'X' in the same IDLE cycle -> clear starts, no 'X' write, drop=1. Assert reset_n=0 at clear cycle 20 -> outputs return to reset values immediately; after release, a full 32-write clear restarts from address 0.

Source files
------------

// File: rtl/lcd_text_controller.sv
// Cursor-based text editor for the 32-cell LCD character RAM.
// It turns decoded key events into RAM writes, and clears the screen after reset and on request.
module lcd_text_controller #(
  parameter int          DEPTH     = 32,
  parameter int          LINE_LEN  = 16,
  parameter int          ADDR_W    = 5,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_valid,
  input  logic              key_make,
  input  logic [7:0]        key_ascii,
  input  logic              clear_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy,
  output logic              drop
);

  // The clear counter has one extra bit, so the edge after the last fill write can be recognised
  localparam int                CNT_W       = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CLR_END     = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LINE2_START = ADDR_W'(LINE_LEN);

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   clrCnt_q, clrCnt_d;
  logic [ADDR_W-1:0]  cursor_q, cursor_d;
  logic               ramWe_q, ramWe_d;
  logic [ADDR_W-1:0]  ramWaddr_q, ramWaddr_d;
  logic [7:0]         ramWdata_q, ramWdata_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;

  logic accepted;
  logic isPrintable;

  assign accepted    = key_valid & key_make;
  assign isPrintable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clrCnt_q   <= '0;
      cursor_q   <= '0;
      ramWe_q    <= 1'b0;
      ramWaddr_q <= '0;
      ramWdata_q <= FILL_CHAR;
      busy_q     <= 1'b1;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clrCnt_q   <= clrCnt_d;
      cursor_q   <= cursor_d;
      ramWe_q    <= ramWe_d;
      ramWaddr_q <= ramWaddr_d;
      ramWdata_q <= ramWdata_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clrCnt_d   = clrCnt_q;
    cursor_d   = cursor_q;
    ramWe_d    = 1'b0;
    ramWaddr_d = ramWaddr_q;
    ramWdata_d = ramWdata_q;
    busy_d     = busy_q;
    drop_d     = 1'b0;

    unique case (state_q)
      CLEAR: begin
        // Keys arriving while clearing are lost, and clear requests do not restart the sweep
        drop_d = accepted;
        if (clrCnt_q == CLR_END) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          cursor_d = '0;
        end else begin
          ramWe_d    = 1'b1;
          ramWaddr_d = clrCnt_q[ADDR_W-1:0];
          ramWdata_d = FILL_CHAR;
          clrCnt_d   = clrCnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (clear_req) begin
          state_d  = CLEAR;
          clrCnt_d = '0;
          busy_d   = 1'b1;
          drop_d   = accepted;
        end else if (accepted) begin
          if (isPrintable) begin
            ramWe_d    = 1'b1;
            ramWaddr_d = cursor_q;
            ramWdata_d = key_ascii;
            cursor_d   = (cursor_q == LAST_CELL) ? '0 : cursor_q + 1'b1;
          end else if (key_ascii == ASCII_BS) begin
            if (cursor_q != '0) begin
              ramWe_d    = 1'b1;
              ramWaddr_d = cursor_q - 1'b1;
              ramWdata_d = FILL_CHAR;
              cursor_d   = cursor_q - 1'b1;
            end
          end else if (key_ascii == ASCII_CR) begin
            cursor_d = (cursor_q < LINE2_START) ? LINE2_START : '0;
          end else if (key_ascii == ASCII_ESC) begin
            state_d  = CLEAR;
            clrCnt_d = '0;
            busy_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d  = CLEAR;
        clrCnt_d = '0;
        busy_d   = 1'b1;
      end
    endcase
  end

  assign ram_we    = ramWe_q;
  assign ram_waddr = ramWaddr_q;
  assign ram_wdata = ramWdata_q;
  assign cursor    = cursor_q;
  assign busy      = busy_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_lcd_text_controller.sv
// Directed self-checking bench for lcd_text_controller.
// It covers the clear sweep, cursor editing, drops while busy, and asynchronous reset in the middle of a clear.
module tb_lcd_text_controller;

  logic       clk;
  logic       reset_n;
  logic       key_valid;
  logic       key_make;
  logic [7:0] key_ascii;
  logic       clear_req;
  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [4:0] cursor;
  logic       busy;
  logic       drop;

  int testsRun;
  int testsFailed;

  lcd_text_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_make  (key_make),
    .key_ascii (key_ascii),
    .clear_req (clear_req),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .cursor    (cursor),
    .busy      (busy),
    .drop      (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One key event: the inputs are held across one rising edge, and the task returns 1 time unit after that edge
  task automatic sendKey(input logic [7:0] ascii, input logic make);
    key_valid = 1'b1;
    key_make  = make;
    key_ascii = ascii;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_make  = 1'b0;
  endtask

  // Follows a clear sweep and reports what it saw. A key or clear_req can be injected at a chosen sweep cycle.
  task automatic watchClear(input int keyAt, input int reqAt, input int abortAt,
                            output int writes, output int orderErrs, output int drops,
                            output int cycles, output int timedOut);
    writes    = 0;
    orderErrs = 0;
    drops     = 0;
    cycles    = 0;
    timedOut  = 1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == abortAt) begin
        timedOut = 0;
        break;
      end
      if (cyc == keyAt) begin
        key_valid = 1'b1;
        key_make  = 1'b1;
        key_ascii = 8'h51;
      end
      if (cyc == reqAt) clear_req = 1'b1;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      key_make  = 1'b0;
      clear_req = 1'b0;
      cycles    = cyc + 1;
      if (ram_we) begin
        if (ram_waddr !== writes[4:0] || ram_wdata !== 8'h20) orderErrs++;
        writes++;
      end
      if (drop) drops++;
      if (!busy) begin
        timedOut = 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int writes, orderErrs, drops, cycles, timedOut;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    testsRun++;
    if (ram_we !== 1'b0 || ram_waddr !== 5'd0 || ram_wdata !== 8'h20) begin
      testsFailed++;
      $display("[TB] FAIL reset_ram: we=%0b addr=%0d data=%0h required we=0 addr=0 data=20", ram_we, ram_waddr, ram_wdata);
    end
    testsRun++;
    if (cursor !== 5'd0 || busy !== 1'b1 || drop !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: cursor=%0d busy=%0b drop=%0b required 0/1/0", cursor, busy, drop);
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    watchClear(-1, -1, -1, writes, orderErrs, drops, cycles, timedOut);
    testsRun++;
    if (timedOut != 0 || writes != 32 || orderErrs != 0 || cycles != 33) begin
      testsFailed++;
      $display("[TB] FAIL power_on_clear: writes=%0d orderErrs=%0d cycles=%0d timeout=%0d required 32/0/33/0", writes, orderErrs, cycles, timedOut);
    end
    testsRun++;
    if (busy !== 1'b0 || cursor !== 5'd0 || ram_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL after_clear: busy=%0b cursor=%0d we=%0b required 0/0/0", busy, cursor, ram_we);
    end
  endtask

  task automatic test_printable;
    sendKey(8'h41, 1'b1);
    testsRun++;
    if (ram_we !== 1'b1 || ram_waddr !== 5'd0 || ram_wdata !== 8'h41 || cursor !== 5'd1) begin
      testsFailed++;
      $display("[TB] FAIL write_A: we=%0b addr=%0d data=%0h cursor=%0d required 1/0/41/1", ram_we, ram_waddr, ram_wdata, cursor);
    end
    sendKey(8'h42, 1'b1);
    testsRun++;
    if (ram_we !== 1'b1 || ram_waddr !== 5'd1 || ram_wdata !== 8'h42 || cursor !== 5'd2) begin
      testsFailed++;
      $display("[TB] FAIL write_B: we=%0b addr=%0d data=%0h cursor=%0d required 1/1/42/2", ram_we, ram_waddr, ram_wdata, cursor);
    end
    sendKey(8'h41, 1'b0);
    testsRun++;
    if (ram_we !== 1'b0 || cursor !== 5'd2 || drop !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL break_code: we=%0b cursor=%0d drop=%0b required 0/2/0", ram_we, cursor, drop);
    end
  endtask

  task automatic test_backspace;
    sendKey(8'h08, 1'b1);
    testsRun++;
    if (ram_we !== 1'b1 || ram_waddr !== 5'd1 || ram_wdata !== 8'h20 || cursor !== 5'd1) begin
      testsFailed++;
      $display("[TB] FAIL bs_from_2: we=%0b addr=%0d data=%0h cursor=%0d required 1/1/20/1", ram_we, ram_waddr, ram_wdata, cursor);
    end
    sendKey(8'h08, 1'b1);
    sendKey(8'h08, 1'b1);
    testsRun++;
    if (ram_we !== 1'b0 || cursor !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL bs_at_0: we=%0b cursor=%0d required 0/0", ram_we, cursor);
    end
    sendKey(8'h43, 1'b1);
    testsRun++;
    if (ram_we !== 1'b1 || ram_waddr !== 5'd0 || ram_wdata !== 8'h43 || cursor !== 5'd1) begin
      testsFailed++;
      $display("[TB] FAIL write_C: we=%0b addr=%0d data=%0h cursor=%0d required 1/0/43/1", ram_we, ram_waddr, ram_wdata, cursor);
    end
    sendKey(8'h08, 1'b1);
    testsRun++;
    if (ram_we !== 1'b1 || ram_waddr !== 5'd0 || ram_wdata !== 8'h20 || cursor !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL bs_after_C: we=%0b addr=%0d data=%0h cursor=%0d required 1/0/20/0", ram_we, ram_waddr, ram_wdata, cursor);
    end
    sendKey(8'h01, 1'b1);
    testsRun++;
    if (ram_we !== 1'b0 || cursor !== 5'd0 || drop !== 1'b0 || ram_waddr !== 5'd0 || ram_wdata !== 8'h20) begin
      testsFailed++;
      $display("[TB] FAIL unknown_code: we=%0b cursor=%0d drop=%0b addr=%0d data=%0h required 0/0/0/0/20", ram_we, cursor, drop, ram_waddr, ram_wdata);
    end
  endtask

  task automatic test_enter_and_wrap;
    logic [7:0] ch;
    for (int i = 0; i < 5; i++) sendKey(8'h30 + 8'(i), 1'b1);
    testsRun++;
    if (cursor !== 5'd5) begin
      testsFailed++;
      $display("[TB] FAIL cursor_5: cursor=%0d required 5", cursor);
    end
    sendKey(8'h0D, 1'b1);
    testsRun++;
    if (cursor !== 5'd16 || ram_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL enter_line2: cursor=%0d we=%0b required 16/0", cursor, ram_we);
    end
    sendKey(8'h0D, 1'b1);
    testsRun++;
    if (cursor !== 5'd0 || ram_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL enter_line1: cursor=%0d we=%0b required 0/0", cursor, ram_we);
    end
    // key_valid stays high across consecutive edges here, so every key arrives back to back
    for (int i = 0; i < 32; i++) begin
      ch        = 8'h41 + 8'(i % 26);
      key_valid = 1'b1;
      key_make  = 1'b1;
      key_ascii = ch;
      @(posedge clk);
      #1;
      testsRun++;
      if (ram_we !== 1'b1 || ram_waddr !== 5'(i) || ram_wdata !== ch) begin
        testsFailed++;
        $display("[TB] FAIL fill_%0d: we=%0b addr=%0d data=%0h required 1/%0d/%0h", i, ram_we, ram_waddr, ram_wdata, i, ch);
      end
    end
    key_valid = 1'b0;
    key_make  = 1'b0;
    testsRun++;
    if (cursor !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_cursor: cursor=%0d required 0", cursor);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (ram_we !== 1'b0 || ram_waddr !== 5'd31) begin
      testsFailed++;
      $display("[TB] FAIL fill_idle: we=%0b addr=%0d required 0/31", ram_we, ram_waddr);
    end
  endtask

  task automatic test_escape_clear;
    int writes, orderErrs, drops, cycles, timedOut;
    sendKey(8'h1B, 1'b1);
    testsRun++;
    if (busy !== 1'b1 || ram_we !== 1'b0 || drop !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL esc_start: busy=%0b we=%0b drop=%0b required 1/0/0", busy, ram_we, drop);
    end
    watchClear(10, 15, -1, writes, orderErrs, drops, cycles, timedOut);
    testsRun++;
    if (timedOut != 0 || writes != 32 || orderErrs != 0 || cycles != 33) begin
      testsFailed++;
      $display("[TB] FAIL esc_clear: writes=%0d orderErrs=%0d cycles=%0d timeout=%0d required 32/0/33/0", writes, orderErrs, cycles, timedOut);
    end
    testsRun++;
    if (drops != 1) begin
      testsFailed++;
      $display("[TB] FAIL busy_drop: drops=%0d required 1", drops);
    end
    testsRun++;
    if (cursor !== 5'd0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL esc_done: cursor=%0d busy=%0b required 0/0", cursor, busy);
    end
  endtask

  task automatic test_clear_collision_and_reset;
    int writes, orderErrs, drops, cycles, timedOut;
    for (int i = 0; i < 3; i++) sendKey(8'h61 + 8'(i), 1'b1);
    key_valid = 1'b1;
    key_make  = 1'b1;
    key_ascii = 8'h58;
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_make  = 1'b0;
    clear_req = 1'b0;
    testsRun++;
    if (drop !== 1'b1 || ram_we !== 1'b0 || busy !== 1'b1 || cursor !== 5'd3) begin
      testsFailed++;
      $display("[TB] FAIL clear_vs_key: drop=%0b we=%0b busy=%0b cursor=%0d required 1/0/1/3", drop, ram_we, busy, cursor);
    end
    watchClear(-1, -1, 20, writes, orderErrs, drops, cycles, timedOut);
    testsRun++;
    if (writes != 20 || orderErrs != 0 || ram_waddr !== 5'd19) begin
      testsFailed++;
      $display("[TB] FAIL partial_clear: writes=%0d orderErrs=%0d addr=%0d required 20/0/19", writes, orderErrs, ram_waddr);
    end
    reset_n = 1'b0;
    #1;
    testsRun++;
    if (ram_we !== 1'b0 || ram_waddr !== 5'd0 || ram_wdata !== 8'h20 || cursor !== 5'd0 || busy !== 1'b1 || drop !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: we=%0b addr=%0d data=%0h cursor=%0d busy=%0b drop=%0b required 0/0/20/0/1/0", ram_we, ram_waddr, ram_wdata, cursor, busy, drop);
    end
    #2 reset_n = 1'b1;
    watchClear(-1, -1, -1, writes, orderErrs, drops, cycles, timedOut);
    testsRun++;
    if (timedOut != 0 || writes != 32 || orderErrs != 0 || cycles != 33 || cursor !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL restart_clear: writes=%0d orderErrs=%0d cycles=%0d timeout=%0d cursor=%0d required 32/0/33/0/0", writes, orderErrs, cycles, timedOut, cursor);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    key_valid   = 1'b0;
    key_make    = 1'b0;
    key_ascii   = 8'h00;
    clear_req   = 1'b0;
    test_reset;
    test_printable;
    test_backspace;
    test_enter_and_wrap;
    test_escape_clear;
    test_clear_collision_and_reset;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
